// File: rtl/svm_classifier_sdiv_pkg.sv
// Shared widths, saturation limits and FSM state type for the SVM classifier
// sequential signed divider.
package svm_classifier_sdiv_pkg;

    localparam int DIVIDEND_W = 26;
    localparam int DIVISOR_W  = 15;
    localparam int QUOTIENT_W = 13;
    localparam int PARTIAL_W  = DIVISOR_W + 1;
    localparam int CNT_W      = 5;

    localparam logic signed [QUOTIENT_W-1:0] QMAX = 13'sh0FFF;
    localparam logic signed [QUOTIENT_W-1:0] QMIN = 13'sh1000;

    // Magnitude limits applied to the unsigned quotient before the sign is restored
    localparam logic [DIVIDEND_W-1:0] POS_LIMIT = 26'd4095;
    localparam logic [DIVIDEND_W-1:0] NEG_LIMIT = 26'd4096;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/svm_classifier_sdiv_step.sv
// One radix-2 restoring division step: shift in the next dividend bit and
// subtract the divisor magnitude when it fits.
module svm_classifier_sdiv_step
    import svm_classifier_sdiv_pkg::*;
(
    input  logic [PARTIAL_W-1:0] partial_i,
    input  logic [DIVISOR_W-1:0] divisor_i,
    input  logic                 bit_i,
    output logic [PARTIAL_W-1:0] partial_o,
    output logic                 qbit_o
);

    logic [PARTIAL_W-1:0] shifted;
    logic [PARTIAL_W-1:0] divisorExt;

    // The restored partial is always below the divisor, so its MSB is zero and can be dropped
    always_comb begin
        shifted    = {partial_i[PARTIAL_W-2:0], bit_i};
        divisorExt = {1'b0, divisor_i};
        partial_o  = shifted;
        qbit_o     = 1'b0;
        if (shifted >= divisorExt) begin
            partial_o = shifted - divisorExt;
            qbit_o    = 1'b1;
        end
    end

endmodule

// File: rtl/svm_classifier_sdiv_26s_15s_13_seq.sv
// Fixed-latency 26s / 15s -> 13s saturating signed divider with an
// ap_ctrl_hs style start/done handshake.
module svm_classifier_sdiv_26s_15s_13_seq
    import svm_classifier_sdiv_pkg::*;
(
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic                         ap_start,
    output logic                         ap_idle,
    output logic                         ap_ready,
    output logic                         ap_done,
    input  logic signed [DIVIDEND_W-1:0] din0,
    input  logic signed [DIVISOR_W-1:0]  din1,
    output logic signed [QUOTIENT_W-1:0] dout,
    output logic signed [DIVISOR_W-1:0]  rem,
    output logic                         ovf,
    output logic                         dz
);

    state_e                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [PARTIAL_W-1:0]         partial_q, partial_d;
    logic [DIVIDEND_W-1:0]        dvd_q, dvd_d;
    logic [DIVIDEND_W-1:0]        quo_q, quo_d;
    logic [DIVISOR_W-1:0]         dmag_q, dmag_d;
    logic [DIVISOR_W-1:0]         dinLo_q, dinLo_d;
    logic                         signA_q, signA_d;
    logic                         signB_q, signB_d;
    logic                         zero_q, zero_d;
    logic signed [QUOTIENT_W-1:0] dout_q, dout_d;
    logic signed [DIVISOR_W-1:0]  rem_q, rem_d;
    logic                         ovf_q, ovf_d;
    logic                         dz_q, dz_d;

    logic [PARTIAL_W-1:0]         stepPartial;
    logic                         stepBit;
    logic [DIVIDEND_W-1:0]        quoNeg;
    logic [DIVISOR_W-1:0]         remMag;

    svm_classifier_sdiv_step u_step (
        .partial_i (partial_q),
        .divisor_i (dmag_q),
        .bit_i     (dvd_q[DIVIDEND_W-1]),
        .partial_o (stepPartial),
        .qbit_o    (stepBit)
    );

    assign quoNeg = -quo_q;
    assign remMag = partial_q[DIVISOR_W-1:0];

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            partial_q <= '0;
            dvd_q     <= '0;
            quo_q     <= '0;
            dmag_q    <= '0;
            dinLo_q   <= '0;
            signA_q   <= 1'b0;
            signB_q   <= 1'b0;
            zero_q    <= 1'b0;
            dout_q    <= '0;
            rem_q     <= '0;
            ovf_q     <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            partial_q <= partial_d;
            dvd_q     <= dvd_d;
            quo_q     <= quo_d;
            dmag_q    <= dmag_d;
            dinLo_q   <= dinLo_d;
            signA_q   <= signA_d;
            signB_q   <= signB_d;
            zero_q    <= zero_d;
            dout_q    <= dout_d;
            rem_q     <= rem_d;
            ovf_q     <= ovf_d;
            dz_q      <= dz_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        partial_d = partial_q;
        dvd_d     = dvd_q;
        quo_d     = quo_q;
        dmag_d    = dmag_q;
        dinLo_d   = dinLo_q;
        signA_d   = signA_q;
        signB_d   = signB_q;
        zero_d    = zero_q;
        dout_d    = dout_q;
        rem_d     = rem_q;
        ovf_d     = ovf_q;
        dz_d      = dz_q;

        case (state_q)
            IDLE: begin
                if (ap_start) begin
                    state_d   = CALC;
                    cnt_d     = CNT_W'(DIVIDEND_W - 1);
                    signA_d   = din0[DIVIDEND_W-1];
                    signB_d   = din1[DIVISOR_W-1];
                    dvd_d     = din0[DIVIDEND_W-1] ? -din0 : din0;
                    dmag_d    = din1[DIVISOR_W-1] ? -din1 : din1;
                    zero_d    = (din1 == '0);
                    dinLo_d   = din0[DIVISOR_W-1:0];
                    partial_d = '0;
                    quo_d     = '0;
                end
            end
            CALC: begin
                partial_d = stepPartial;
                dvd_d     = {dvd_q[DIVIDEND_W-2:0], 1'b0};
                quo_d     = {quo_q[DIVIDEND_W-2:0], stepBit};
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            // Sign restoration and saturation land in the output registers on the edge into DONE
            FIX: begin
                state_d = DONE;
                if (zero_q) begin
                    dout_d = signA_q ? QMIN : QMAX;
                    rem_d  = dinLo_q;
                    ovf_d  = 1'b0;
                    dz_d   = 1'b1;
                end else begin
                    dz_d  = 1'b0;
                    rem_d = signA_q ? -remMag : remMag;
                    if (signA_q ^ signB_q) begin
                        ovf_d  = (quo_q > NEG_LIMIT);
                        dout_d = (quo_q > NEG_LIMIT) ? QMIN : quoNeg[QUOTIENT_W-1:0];
                    end else begin
                        ovf_d  = (quo_q > POS_LIMIT);
                        dout_d = (quo_q > POS_LIMIT) ? QMAX : quo_q[QUOTIENT_W-1:0];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ap_idle  = (state_q == IDLE);
    assign ap_done  = (state_q == DONE);
    assign ap_ready = (state_q == DONE);
    assign dout     = dout_q;
    assign rem      = rem_q;
    assign ovf      = ovf_q;
    assign dz       = dz_q;

endmodule
